// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed program image from a valid/ready byte source into program memory.
// Latency: one memory write per accepted payload byte, one cycle after the byte transfer; throughput one byte per cycle.
// Backpressure: in_ready is high only in LEN/DATA/CHK and never while start is high. DONE and ERR hold in_ready low.
//
// Ports:
//   clk, rst_n          single clock; asynchronous active-low reset
//   start               one-cycle pulse that begins or restarts a load
//   in_valid/in_ready   byte stream handshake; in_data carries length, payload, optional checksum
//   mem_addr/mem_data   registered write address and data toward program memory
//   memWE               registered write strobe, one cycle per payload byte
//   cpu_halt            keeps the CPU frozen while a load is pending or has failed
//   done/err            level status of the last load, cleared by start
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to add the CHK state.
// With it, a trailing checksum byte must bring the 8-bit sum of the length and payload bytes to zero.
// Without it, there is no checksum logic and err is tied low.
module prog_loader #(
   parameter logic [7:0] BASE_ADDR     = 8'h00,
   parameter bit          HALT_ON_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       memWE,
   output logic       cpu_halt,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      DONE = 3'd3
`ifdef PROG_LOADER_CHECKSUM_EN
      ,
      CHK  = 3'd4,
      ERR  = 3'd5
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] addr_q, addr_d;        // next payload address
   logic [8:0] rem_q, rem_d;          // payload bytes still expected (a length byte of 0 means 256)
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       we_q, we_d;
   logic       halt_q, halt_d;
   logic       xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic [7:0] sum_final;
`endif

   assign in_ready = ((state_q == LEN) || (state_q == DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                      || (state_q == CHK)
`endif
                     ) && !start;
   assign xfer = in_valid && in_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
   assign sum_final = sum_q + in_data;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      we_d      = 1'b0;
      halt_d    = halt_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d     = sum_q;
`endif

      if (start) begin
         // start takes precedence in every state. in_ready is low, so a byte offered now is not consumed.
         state_d = LEN;
         addr_d  = BASE_ADDR;
         rem_d   = 9'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_d   = 8'd0;
`endif
      end else begin
         case (state_q)
            LEN: begin
               if (xfer) begin
                  rem_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  addr_d  = BASE_ADDR;
                  state_d = DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum_d   = in_data;
`endif
               end
            end
            DATA: begin
               if (xfer) begin
                  we_d      = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = in_data;
                  addr_d    = addr_q + 8'd1;   // wraps mod 256
                  rem_d     = rem_q - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum_d     = sum_q + in_data;
                  if (rem_q == 9'd1) state_d = CHK;
`else
                  if (rem_q == 9'd1) state_d = DONE;
`endif
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
               if (xfer) state_d = (sum_final == 8'd0) ? DONE : ERR;
            end
`endif
            default: ;
         endcase
      end

      // Halt is registered from the next state, so it rises on the same edge that enters LEN.
      // On the edge that enters DONE it stays high; it drops one cycle later, after the last write strobe.
      case (state_d)
         IDLE:    halt_d = HALT_ON_RESET;
         DONE:    halt_d = (state_q != DONE);
         default: halt_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= BASE_ADDR;
         rem_q     <= 9'd0;
         wr_addr_q <= BASE_ADDR;
         wr_data_q <= 8'd0;
         we_q      <= 1'b0;
         halt_q    <= HALT_ON_RESET;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         we_q      <= we_d;
         halt_q    <= halt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   assign mem_addr = wr_addr_q;
   assign mem_data = wr_data_q;
   assign memWE    = we_q;
   assign cpu_halt = halt_q;
   assign done     = (state_q == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
   assign err      = (state_q == ERR);
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader.
// It drives two instances from the same stimulus: base 00 with halt-on-reset, and base FE without halt-on-reset.
// Expected writes are queued per instance when payload bytes are driven, and popped when memWE is seen.
module tb_prog_loader;

   localparam logic [7:0] BASE0 = 8'h00;
   localparam logic [7:0] BASE1 = 8'hFE;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       rdy0, rdy1, we0, we1, halt0, halt1, done0, done1, err0, err1;
   logic [7:0] a0, a1, d0, d1;

   int          n_vec = 0;
   int          n_miss = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [15:0] e0, e1;
   logic [7:0]  pl[$];

   always #5 clk = ~clk;

   prog_loader #(.BASE_ADDR(BASE0), .HALT_ON_RESET(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .mem_addr(a0), .mem_data(d0), .memWE(we0),
      .cpu_halt(halt0), .done(done0), .err(err0));

   prog_loader #(.BASE_ADDR(BASE1), .HALT_ON_RESET(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .mem_addr(a1), .mem_data(d1), .memWE(we1),
      .cpu_halt(halt1), .done(done1), .err(err1));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (we0) begin
         if (q0.size() == 0) chk("d0_extra_we", we0, 1'b0);
         else begin
            e0 = q0.pop_front();
            chk("d0_addr", a0, e0[15:8]);
            chk("d0_data", d0, e0[7:0]);
         end
      end
      if (we1) begin
         if (q1.size() == 0) chk("d1_extra_we", we1, 1'b0);
         else begin
            e1 = q1.pop_front();
            chk("d1_addr", a1, e1[15:8]);
            chk("d1_data", d1, e1[7:0]);
         end
      end
   end

   task automatic push(input int idx, input logic [7:0] b);
      logic [7:0] off, ad0, ad1;
      off = 8'(idx);
      ad0 = BASE0 + off;
      ad1 = BASE1 + off;
      q0.push_back({ad0, b});
      q1.push_back({ad1, b});
   endtask

   // Offer one byte, hold it until accepted, then return just after the following negedge.
   task automatic send(input logic [7:0] b, input int gap_max);
      int t;
      int n;
      n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (n) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      #1;
      chk("rdy_match", rdy1, rdy0);
      t = 0;
      while (!rdy0) begin
         @(negedge clk);
         #1;
         t++;
         if (t > 50) begin
            chk("ready_timeout", rdy0, 1'b1);
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic pulse_start(input logic hold_valid);
      start    = 1'b1;
      in_valid = hold_valid;
      in_data  = 8'hEE;
      #1;
      chk("rdy_during_start", rdy0, 1'b0);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("halt0_in_len", halt0, 1'b1);
      chk("halt1_in_len", halt1, 1'b1);
      chk("done_cleared", done0, 1'b0);
      chk("err_cleared", err1, 1'b0);
      chk("rdy_in_len", rdy0, 1'b1);
   endtask

   // Full load of pl[] with the given length byte; bad selects a wrong checksum.
   task automatic load(input logic [7:0] len, input int gap, input bit bad, input bit do_start);
      logic [7:0] sum;
      int n;
      n = (len == 8'd0) ? 256 : int'(len);
      if (do_start) pulse_start(1'b0);
      send(len, gap);
      sum = len;
      for (int i = 0; i < n; i++) begin
         sum = sum + pl[i];
         push(i, pl[i]);
         send(pl[i], gap);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send(bad ? (~sum + 8'd2) : (~sum + 8'd1), gap);
`endif
      @(negedge clk);
      #1;
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      if (!bad) begin
         chk("done0", done0, 1'b1);
         chk("done1", done1, 1'b1);
         chk("err0_ok", err0, 1'b0);
         chk("halt0_released", halt0, 1'b0);
         chk("halt1_released", halt1, 1'b0);
      end else begin
         chk("err0", err0, 1'b1);
         chk("done0_on_err", done0, 1'b0);
         chk("halt0_on_err", halt0, 1'b1);
         chk("halt1_on_err", halt1, 1'b1);
      end
      // The final state must ignore a stuck-high source; any strobe here is caught by the monitor.
      in_valid = 1'b1;
      in_data  = 8'h5A;
      #1;
      chk("rdy_final", rdy0, 1'b0);
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("done_hold", done0, bad ? 1'b0 : 1'b1);
   endtask

   task automatic chk_reset();
      chk("rst_rdy0", rdy0, 1'b0);
      chk("rst_we0", we0, 1'b0);
      chk("rst_we1", we1, 1'b0);
      chk("rst_addr0", a0, BASE0);
      chk("rst_addr1", a1, BASE1);
      chk("rst_data0", d0, 8'h00);
      chk("rst_halt0", halt0, 1'b1);
      chk("rst_halt1", halt1, 1'b0);
      chk("rst_done0", done0, 1'b0);
      chk("rst_err0", err0, 1'b0);
   endtask

   initial begin
      logic [7:0] b;
      repeat (2) @(negedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;
      // IDLE ignores data
      in_valid = 1'b1;
      in_data  = 8'h33;
      @(negedge clk);
      #1;
      chk("idle_rdy", rdy0, 1'b0);
      chk("idle_halt1", halt1, 1'b0);
      in_valid = 1'b0;

      // basic stream A1 B2 C3, continuous valid
      pl = {8'hA1, 8'hB2, 8'hC3};
      load(8'd3, 0, 1'b0, 1'b1);

      // four bytes: instance 1 wraps FE,FF,00,01
      pl.delete();
      for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
      load(8'd4, 0, 1'b0, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
      pl = {8'h10, 8'h20};
      load(8'd2, 0, 1'b0, 1'b1);
      load(8'd2, 0, 1'b1, 1'b1);
`endif

      // random gaps on a five-byte payload
      pl.delete();
      for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
      load(8'd5, 3, 1'b0, 1'b1);

      // restart after two of four payload bytes; byte offered with start is dropped
      pulse_start(1'b0);
      send(8'd4, 0);
      push(0, 8'h11);
      send(8'h11, 0);
      push(1, 8'h22);
      send(8'h22, 0);
      pulse_start(1'b1);
      pl = {8'h55, 8'h66};
      load(8'd2, 0, 1'b0, 1'b0);

      // reset while in DATA: the strobe drops immediately
      pulse_start(1'b0);
      send(8'd4, 0);
      b = 8'h9C;
      push(0, b);
      send(b, 0);
      rst_n = 1'b0;
      #1;
      chk_reset();
      chk("rst_q_empty", q0.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      pl = {8'h01, 8'h02, 8'h03};
      load(8'd3, 1, 1'b0, 1'b1);

      // length 0 means 256 bytes covering every address
      pl.delete();
      for (int i = 0; i < 256; i++) pl.push_back(8'($urandom));
      load(8'd0, 0, 1'b0, 1'b1);

      // next load starts back at the base address
      pl = {8'h7E};
      load(8'd1, 0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: BASE_ADDR, 8'h00, first memory address written by a load.
REQ-002 Parameter: HALT_ON_RESET, 1, 1 = cpu_halt high out of reset, 0 = low out of reset.
REQ-003 Port: clk  in  1  single clock, all state changes on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: start  in  1  one-cycle pulse that begins (or restarts) a program load.
REQ-006 Port: in_valid  in  1  source presents a byte on in_data.
REQ-007 Port: in_data  in  8  byte stream: length byte, then payload, then optional checksum.
REQ-008 Port: in_ready  out  1  loader accepts in_data this cycle; transfer occurs when in_valid && in_ready.
REQ-009 Port: mem_addr  out  8  write address to program memory.
REQ-010 Port: mem_data  out  8  write data to program memory (regOut-side port).
REQ-011 Port: memWE  out  1  memory write enable, one cycle per payload byte.
REQ-012 Port: cpu_halt  out  1  holds PC/control frozen while high.
REQ-013 Port: done  out  1  load completed successfully; level until next start.
REQ-014 Port: err  out  1  load failed checksum; level until next start.

Function
REQ-015 FSM states SHALL be IDLE, LEN, DATA, CHK, DONE, ERR.
REQ-016 IDLE: start -> LEN; cpu_halt per HALT_ON_RESET; in_ready=0.
REQ-017 LEN: accepted byte L stored as count; L=0 means 256 bytes; -> DATA; addr counter <= BASE_ADDR.
REQ-018 DATA: each accepted byte -> registered write next cycle: memWE=1, mem_addr=counter, mem_data=byte; counter increments mod 256.
REQ-019 DATA: after the L-th byte is accepted -> CHK if checksum is enabled, else DONE.
REQ-020 in_ready SHALL equal (state in {LEN,DATA,CHK}) && !start; no byte is lost or duplicated under any in_valid pattern, including in_valid stuck high.
REQ-021 memWE SHALL be 0 in every cycle not directly following a DATA-state transfer; maximum one write per cycle, throughput one byte/cycle.
REQ-022 Address wrap: BASE_ADDR+count beyond 255 wraps to 0; no error.
REQ-023 cpu_halt SHALL be 1 in LEN, DATA, CHK, ERR; 0 in DONE, asserted the same edge that enters LEN.
REQ-024 done=1 only in DONE; err=1 only in ERR; cpu_halt deasserts the cycle after the final memWE.
REQ-025 start in any state SHALL restart at LEN, clear done/err, reset count and checksum; a byte offered the same cycle is not accepted.
REQ-026 DONE and ERR SHALL ignore in_valid; only start or reset leaves them.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counter=BASE_ADDR, memWE=0, done=0, err=0, in_ready=0, mem_addr=BASE_ADDR, mem_data=0, cpu_halt=HALT_ON_RESET.
REQ-028 Reset mid-load SHALL abort with no further memWE; bytes already written remain in memory.

Configuration
REQ-029 Macro PROG_LOADER_CHECKSUM_EN defined: CHK state present; running 8-bit sum covers length byte and payload; checksum byte makes total sum mod 256 = 0 -> DONE, else ERR.
REQ-030 Macro undefined: no CHK state, no checksum logic, err tied 0, DATA goes straight to DONE.

Verification
REQ-031 Reset, start, stream 03,A1,B2,C3 (checksum off), in_valid continuous -> memWE at addr 00,01,02 data A1,B2,C3 on consecutive cycles; done=1, cpu_halt=0 after last write.
REQ-032 BASE_ADDR=FE, length 04 -> writes to FE,FF,00,01; done=1.
REQ-033 Checksum on: 02,10,20,CE -> done=1; 02,10,20,CF -> err=1, cpu_halt stays 1, no extra memWE.
REQ-034 Random in_valid gaps on 05-byte payload -> exactly 5 memWE, data/address in order, none duplicated.
REQ-035 start pulsed after 2 of 4 payload bytes -> next byte treated as new length, addr restarts at BASE_ADDR; rst_n low mid-DATA -> memWE=0 same cycle, state IDLE.
REQ-036 Length 00 -> 256 writes covering every address once, counter wraps back to BASE_ADDR, done=1.
